// File: rtl/seq_lock_checker.sv
// Sequence lock checker: code entry, open/fail/lockout FSM with registered outputs.
// Define SEQ_PROG_EN to add prog_en for reprogramming the stored code while open.
module seq_lock_checker #(
    parameter int                    DIGITS      = 4,
    parameter logic [4*DIGITS-1:0]   CODE        = 16'h2580,
    parameter int                    MAX_TRIES   = 3,
    parameter int                    LOCKOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  times_up,
    input  logic [4*DIGITS-1:0]   sequence_i,
    input  logic                  new_seq,
`ifdef SEQ_PROG_EN
    input  logic                  prog_en,
`endif
    output logic                  unlock,
    output logic                  error,
    output logic                  start_time,
    output logic                  locked_out,
    output logic [3:0]            fail_cnt
);

    localparam int CW   = 4 * DIGITS;
    localparam int CNTW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(LOCKOUT_CYC - 1);
    localparam logic [3:0] MAXT = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        OPEN,
        FAIL,
        LOCKOUT
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     code_q, code_d;
    logic [CW-1:0]     cap_q, cap_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [3:0]        fc_q, fc_d;
    logic [3:0]        fc_inc;
    logic              unlock_q, unlock_d;
    logic              error_q, error_d;
    logic              start_q, start_d;
    logic              lock_q, lock_d;

    assign fc_inc = (fc_q >= MAXT) ? MAXT : fc_q + 4'd1;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cap_d   = cap_q;
        cnt_d   = cnt_q;
        fc_d    = fc_q;
        unique case (state_q)
            IDLE: begin
                if (new_seq) begin
                    cap_d   = sequence_i;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (cap_q == code_q) begin
                    state_d = OPEN;
                    fc_d    = 4'd0;
                end else begin
                    fc_d = fc_inc;
                    if (fc_inc == MAXT) begin
                        state_d = LOCKOUT;
                        cnt_d   = '0;
                    end else begin
                        state_d = FAIL;
                    end
                end
            end
            OPEN: begin
`ifdef SEQ_PROG_EN
                if (prog_en) begin
                    code_d = sequence_i;
                end
`endif
                if (times_up) begin
                    state_d = IDLE;
                end
            end
            FAIL: begin
                if (times_up) begin
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                // Lockout length is fixed; the external timer plays no part here.
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    fc_d    = 4'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with it when registered.
    always_comb begin
        unlock_d = (state_d == OPEN);
        error_d  = (state_d == FAIL) || (state_d == LOCKOUT);
        lock_d   = (state_d == LOCKOUT);
        start_d  = (state_d != state_q) &&
                   ((state_d == OPEN) || (state_d == FAIL) ||
                    (state_d == LOCKOUT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            code_q   <= CODE;
            cap_q    <= '0;
            cnt_q    <= '0;
            fc_q     <= 4'd0;
            unlock_q <= 1'b0;
            error_q  <= 1'b0;
            start_q  <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            cap_q    <= cap_d;
            cnt_q    <= cnt_d;
            fc_q     <= fc_d;
            unlock_q <= unlock_d;
            error_q  <= error_d;
            start_q  <= start_d;
            lock_q   <= lock_d;
        end
    end

    assign unlock     = unlock_q;
    assign error      = error_q;
    assign start_time = start_q;
    assign locked_out = lock_q;
    assign fail_cnt   = fc_q;

endmodule

// File: tb/tb_seq_lock_checker.sv
// Randomized self-checking bench for seq_lock_checker against a
// transaction-level model of code, failure count and lockout.
module tb_seq_lock_checker;

    localparam int MAXT = 3;
    localparam int LCYC = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        times_up = 1'b0;
    logic [15:0] seq = 16'h0;
    logic        new_seq = 1'b0;
`ifdef SEQ_PROG_EN
    logic        prog_en = 1'b0;
`endif
    logic        unlock, error, start_time, locked_out;
    logic [3:0]  fail_cnt;
    logic [7:0]  obs;

    int          total = 0;
    int          bad = 0;
    logic [15:0] m_code = 16'h2580;
    int          m_fc = 0;

    seq_lock_checker #(
        .DIGITS(4),
        .CODE(16'h2580),
        .MAX_TRIES(MAXT),
        .LOCKOUT_CYC(LCYC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .times_up(times_up),
        .sequence_i(seq),
        .new_seq(new_seq),
`ifdef SEQ_PROG_EN
        .prog_en(prog_en),
`endif
        .unlock(unlock),
        .error(error),
        .start_time(start_time),
        .locked_out(locked_out),
        .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {unlock, error, locked_out, start_time, fail_cnt};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One code entry from IDLE, through the result state, back to IDLE.
    task automatic run_txn(input logic [15:0] code, input bit early,
                           input string tag);
        logic [7:0] exp;
        bit         open, lock;
        int         w;
        seq      = code;
        new_seq  = 1'b1;
        times_up = 1'($urandom_range(0, 1));
        tick();
        new_seq  = 1'b0;
        seq      = 16'($urandom);
        exp = {4'b0000, 4'(m_fc)};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s/check got=%b want=%b", tag, obs, exp);
        end
        times_up = early;
        tick();
        open = (code == m_code);
        if (open) m_fc = 0;
        else if (m_fc < MAXT) m_fc++;
        lock = !open && (m_fc == MAXT);
        exp = {open, !open, lock, 1'b1, 4'(m_fc)};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s/result got=%b want=%b", tag, obs, exp);
        end
        if (lock) begin
            for (int i = 1; i < LCYC; i++) begin
                new_seq  = 1'b1;
                seq      = 16'h2580;
                times_up = 1'($urandom_range(0, 1));
                tick();
                exp = {4'b0110, 4'(m_fc)};
                total++;
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL %s/lock%0d got=%b want=%b",
                             tag, i, obs, exp);
                end
            end
            new_seq  = 1'b0;
            times_up = 1'b0;
            tick();
            m_fc = 0;
            exp = 8'h00;
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL %s/lockend got=%b want=%b", tag, obs, exp);
            end
            tick();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL %s/lockidle got=%b want=%b", tag, obs, exp);
            end
        end else if (early) begin
            tick();
            times_up = 1'b0;
            exp = {4'b0000, 4'(m_fc)};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL %s/early got=%b want=%b", tag, obs, exp);
            end
        end else begin
            w = $urandom_range(0, 3);
            for (int i = 0; i <= w; i++) begin
                new_seq = 1'($urandom_range(0, 1));
                seq     = m_code;
                tick();
                exp = {open, !open, 2'b00, 4'(m_fc)};
                total++;
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL %s/hold%0d got=%b want=%b",
                             tag, i, obs, exp);
                end
            end
            new_seq  = 1'b0;
            times_up = 1'b1;
            tick();
            times_up = 1'b0;
            exp = {4'b0000, 4'(m_fc)};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL %s/release got=%b want=%b", tag, obs, exp);
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        new_seq  = 1'b1;
        seq      = 16'h2580;
        times_up = 1'b1;
        tick();
        tick();
        total++;
        if (obs !== 8'h00) begin
            bad++;
            $display("FAIL reset got=%b want=%b", obs, 8'h00);
        end
        reset    = 1'b0;
        new_seq  = 1'b0;
        times_up = 1'b0;
        tick();
        m_code = 16'h2580;
        m_fc   = 0;
        total++;
        if (obs !== 8'h00) begin
            bad++;
            $display("FAIL reset_prio got=%b want=%b", obs, 8'h00);
        end
    endtask

    task automatic test_open();
        run_txn(16'h2580, 1'b0, "open");
    endtask

    task automatic test_fail();
        run_txn(16'h1234, 1'b0, "fail");
        run_txn(16'h2580, 1'b0, "fail_clr");
    endtask

    task automatic test_lockout();
        run_txn(16'h1234, 1'b0, "lk1");
        run_txn(16'hABCD, 1'b0, "lk2");
        run_txn(16'h1122, 1'b0, "lk3");
        run_txn(16'h2580, 1'b0, "lk_after");
    endtask

    task automatic test_recover();
        run_txn(16'h1010, 1'b0, "rc1");
        run_txn(16'h123A, 1'b0, "rc2");
        run_txn(16'h2580, 1'b0, "rc_ok");
    endtask

    task automatic test_early_timesup();
        run_txn(16'h2580, 1'b1, "early_open");
        run_txn(16'h5555, 1'b1, "early_fail");
        run_txn(16'h2580, 1'b1, "early_clr");
    endtask

    task automatic test_reset_mid();
        seq     = 16'h2580;
        new_seq = 1'b1;
        tick();
        new_seq = 1'b0;
        tick();
        total++;
        if (obs !== 8'b1001_0000) begin
            bad++;
            $display("FAIL rst_open_pre got=%b want=%b", obs, 8'b1001_0000);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (obs !== 8'h00) begin
            bad++;
            $display("FAIL rst_open got=%b want=%b", obs, 8'h00);
        end
        m_fc = 0;
        run_txn(16'h2580, 1'b0, "rst_open_next");
        run_txn(16'h0001, 1'b0, "rst_lk1");
        run_txn(16'h0002, 1'b0, "rst_lk2");
        seq     = 16'h0003;
        new_seq = 1'b1;
        tick();
        new_seq = 1'b0;
        tick();
        total++;
        if (obs !== 8'b0111_0011) begin
            bad++;
            $display("FAIL rst_lk_pre got=%b want=%b", obs, 8'b0111_0011);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (obs !== 8'h00) begin
            bad++;
            $display("FAIL rst_lk got=%b want=%b", obs, 8'h00);
        end
        m_fc = 0;
        run_txn(16'h2580, 1'b0, "rst_lk_next");
    endtask

    task automatic test_random();
        logic [15:0] c;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) c = m_code;
            else c = 16'($urandom);
            run_txn(c, 1'($urandom_range(0, 1)), "rand");
        end
    endtask

`ifdef SEQ_PROG_EN
    task automatic test_prog();
        seq     = m_code;
        new_seq = 1'b1;
        tick();
        new_seq = 1'b0;
        tick();
        m_fc    = 0;
        prog_en = 1'b1;
        seq     = 16'h1111;
        tick();
        prog_en = 1'b0;
        m_code  = 16'h1111;
        total++;
        if (obs !== 8'b1000_0000) begin
            bad++;
            $display("FAIL prog_hold got=%b want=%b", obs, 8'b1000_0000);
        end
        times_up = 1'b1;
        tick();
        times_up = 1'b0;
        run_txn(16'h1111, 1'b0, "prog_new");
        run_txn(16'h2580, 1'b0, "prog_old");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_code = 16'h2580;
        m_fc   = 0;
        run_txn(16'h2580, 1'b0, "prog_rst");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        tick();
        test_reset();
        test_open();
        test_fail();
        test_lockout();
        test_recover();
        test_early_timesup();
        test_reset_mid();
        test_random();
`ifdef SEQ_PROG_EN
        test_prog();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_lock_checker.md
SEQ_LOCK_CHECKER -- requirements
Module: seq_lock_checker

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, meaning the number of 4-bit code digits; code width CW = 4*DIGITS.
REQ-002 The block SHALL have parameter CODE, default 16'h2580, meaning the reset-time unlock code, CW bits.
REQ-003 The block SHALL have parameter MAX_TRIES, default 3, meaning the consecutive failures that trigger lockout; range 1..15.
REQ-004 The block SHALL have parameter LOCKOUT_CYC, default 16, meaning the lockout duration in clk cycles; minimum 1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port times_up, input, 1 bit: external timer expiry, level-sampled.
REQ-008 The block SHALL have port sequence, input, CW bits: the entered code.
REQ-009 The block SHALL have port new_seq, input, 1 bit: sequence valid, level-sampled.
REQ-010 The block SHALL have port unlock, output, 1 bit: code accepted, lock open.
REQ-011 The block SHALL have port error, output, 1 bit: code rejected, or lockout active.
REQ-012 The block SHALL have port start_time, output, 1 bit: one-cycle pulse that starts the external timer.
REQ-013 The block SHALL have port locked_out, output, 1 bit: lockout active.
REQ-014 The block SHALL have port fail_cnt, output, 4 bits: current consecutive-failure count.

Function
REQ-015 The FSM SHALL have states IDLE, CHECK, OPEN, FAIL and LOCKOUT; all outputs SHALL be registered.
REQ-016 In IDLE with new_seq=1 at an edge, the block SHALL capture sequence and enter CHECK.
REQ-017 At the next edge in CHECK, a match against the stored code SHALL enter OPEN, and fail_cnt SHALL clear to 0.
REQ-018 At that same edge, a mismatch SHALL increment fail_cnt; the block SHALL enter LOCKOUT if the new count equals MAX_TRIES, otherwise FAIL.
REQ-019 Latency: unlock, error or locked_out SHALL be high in the cycle after the second edge counted from new_seq sampling.
REQ-020 start_time SHALL pulse high for exactly one cycle, in the first cycle of OPEN, FAIL or LOCKOUT.
REQ-021 Outputs by state: OPEN holds unlock=1; FAIL holds error=1; LOCKOUT holds error=1 and locked_out=1; IDLE and CHECK hold unlock, error and locked_out at 0.
REQ-022 OPEN and FAIL SHALL return to IDLE at the first edge with times_up=1; a times_up already high on entry SHALL be honoured at the following edge.
REQ-023 LOCKOUT SHALL ignore times_up, count LOCKOUT_CYC cycles, then return to IDLE with fail_cnt=0.
REQ-024 new_seq SHALL be ignored in every state except IDLE, and times_up SHALL be ignored in IDLE and CHECK.
REQ-025 fail_cnt SHALL persist across FAIL->IDLE and SHALL saturate at MAX_TRIES.

Reset
REQ-026 Reset SHALL force, at the next edge and in any state: IDLE, unlock=0, error=0, start_time=0, locked_out=0, fail_cnt=0, lockout counter=0, stored code=CODE.
REQ-027 Reset SHALL take priority over new_seq, times_up and prog_en in the same cycle.

Configuration
REQ-028 With macro SEQ_PROG_EN defined, the block SHALL add input prog_en (1 bit); prog_en=1 in OPEN SHALL load sequence as the new stored code at that edge, with the state unchanged.
REQ-029 With SEQ_PROG_EN undefined, the block SHALL have no prog_en port, and the stored code SHALL be constant CODE.

Verification (DIGITS=4, CODE=16'h2580, MAX_TRIES=3, LOCKOUT_CYC=8)
REQ-030 Correct code 16'h2580 with new_seq=1 -> unlock=1 two edges later, one-cycle start_time pulse, error=0; times_up=1 -> unlock=0 and state IDLE.
REQ-031 Wrong code 16'h1234 -> error=1, fail_cnt=1, start_time pulse; times_up=1 -> error=0 and fail_cnt remains 1.
REQ-032 Wrong codes 16'h1234, 16'hABCD, 16'h1122 -> the third gives locked_out=1, error=1, fail_cnt=3; 16'h2580 during lockout is ignored; after 8 cycles locked_out=0 and fail_cnt=0.
REQ-033 Wrong codes 16'h1010 and 16'h123A, then 16'h2580 -> unlock=1 and fail_cnt=0.
REQ-034 Reset asserted in OPEN and in LOCKOUT -> all outputs 0 at the next edge; next 16'h2580 unlocks normally.
REQ-035 With SEQ_PROG_EN defined: in OPEN, prog_en=1 with sequence=16'h1111 -> 16'h1111 later unlocks and 16'h2580 errors; after reset 16'h2580 unlocks again.
